calc_agg_mc: RTL
================

# calc_agg_mc

Multi-channel successor to the single-channel `calc` aggregator. It counts incoming 1-bits on CH bit-serial lanes over a fixed window of WIN enabled cycles. At each window boundary it snapshots every lane's count and serialises the results to the ALU over a valid/ready port, one lane per transfer. Each result carries a threshold activation flag. The block sits between the bit-serial input front end and the ALU.

## Interface
- `CH`, 4, number of serial input lanes (≥1)
- `agg_width`, 12, accumulator width per lane
- `alu_width`, 12, width of the result bus to the ALU
- `WIN`, 16, window length in enabled cycles (must be ≥ CH; elaboration error otherwise)
- `clk` input 1: single clock, all state updates on rising edge
- `rst` input 1: asynchronous, active-low reset
- `calc_1` input 1: count enable; low freezes window counter and accumulators
- `calc_in` input CH: one serial bit per lane
- `thresh` input agg_width: activation threshold, sampled at snapshot
- `agg_out2alu` output alu_width: current lane's result
- `agg_ch` output max(1,$clog2(CH)): lane index of `agg_out2alu`
- `agg_out_valid` output 1: result valid
- `agg_out_ready` input 1: ALU accepts result
- `agg_out_acted` output 1: lane count ≥ sampled threshold
- `agg_overrun` output 1: sticky, a window snapshot was dropped

## Operation
- Window counter `wcnt` runs 0..WIN-1 and advances only when `calc_1`=1. It wraps to 0 after WIN-1.
- When `calc_1`=1, each lane updates `acc[c] <= sat(acc[c] + calc_in[c])`. The sum saturates at 2^agg_width−1 and never wraps.
- Snapshot event: `calc_1`=1 and `wcnt`=WIN-1.
  - The snapshot value includes that cycle's bit.
  - All `acc` registers load 0 on the same edge, so the new window starts from 0.
  - Each lane's `act[c] = (value ≥ thresh)` is computed with the `thresh` present on that edge.
- Result buffer: CH entries of {value, act}. FSM states:
  - IDLE: `agg_out_valid`=0. On a snapshot, load the buffer, set `agg_ch`=0, and go to DRAIN.
  - DRAIN: `agg_out_valid`=1. On `valid && ready`: if `agg_ch`<CH-1, increment `agg_ch`; else go to IDLE.
- Snapshot while in DRAIN:
  - If the same edge completes the final transfer (`agg_ch`=CH-1, ready=1), the snapshot is accepted. The FSM stays in DRAIN with `agg_ch`=0 and the new data.
  - Otherwise the snapshot is discarded and `agg_overrun` is set. Accumulators still clear.
- `agg_out2alu` = buffered value, zero-extended if alu_width > agg_width. If alu_width < agg_width, it saturates to 2^alu_width−1.
- `agg_out_acted` uses the unsaturated comparison.
- Outputs are stable while valid=1 and ready=0.
- `agg_overrun` clears only on reset.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - `wcnt`=0, all `acc`=0, FSM=IDLE
  - `agg_out_valid`=0, `agg_out2alu`=0, `agg_ch`=0, `agg_out_acted`=0, `agg_overrun`=0
- Reset takes effect immediately, including mid-window or mid-drain. In-flight results are lost. Deassertion is synchronised by the integrator; the first count occurs on the first rising edge with `rst`=1.
- Latency: `agg_out_valid` rises 1 cycle after the snapshot edge, presenting lane 0.
- With ready held high, lanes 0..CH-1 appear on CH consecutive cycles. `agg_out_valid` falls the cycle after lane CH-1 transfers, unless a snapshot coincided with that transfer.
- `agg_out_ready` is combinational into the FSM. No combinational path exists from `agg_out_ready` to `agg_out_valid` or the data outputs.
- `calc_1`=0 during DRAIN does not stall draining. `calc_1`=0 on the WIN-1 cycle postpones the snapshot.

## Test plan
Configuration: CH=4, agg_width=12, alu_width=12, WIN=8.

1. Reset value check: hold `rst`=0 with random inputs. All outputs must read 0. Release reset, drive `calc_in`=4'b0000 for 8 cycles with ready=1. Expect 4 results of 0, `agg_ch` 0..3, acted=1 when `thresh`=0.
2. Lane independence: drive lane0 all ones, lane1 alternating starting at 1, lanes 2 and 3 zero, with `thresh`=4 and ready=1. Expect values 8, 4, 0, 0 and acted 1, 1, 0, 0.
3. `calc_1` gating: deassert `calc_1` for 3 cycles mid-window with lane0=1 throughout. Lane0 result = 8, and valid rises 3 cycles later than in scenario 2.
4. Backpressure and overrun: hold ready=0 through a full second window. Lane 0 stays stable with valid=1, and the second snapshot is dropped with `agg_overrun`=1. Release ready; exactly 4 transfers of the first window's data follow.
5. Coincident accept: with ready=1 and WIN=CH=4, run continuous windows. The final transfer coincides with the next snapshot every window. Expect valid to stay high continuously with no overrun.
6. Saturation: use agg_width=3, WIN=16, lane0 all ones. Expect result 7, not 0, with acted set for `thresh`=7. Then assert `rst`=0 mid-drain: valid must drop immediately and all outputs return to 0.

Source files
------------

// File: rtl/calc_agg_mc.sv
// Multi-lane window bit counter: counts 1-bits per lane over WIN enabled cycles,
// snapshots all lanes at the window boundary and drains them one lane per valid/ready transfer.
module calc_agg_mc #(
    parameter int CH        = 4,
    parameter int agg_width = 12,
    parameter int alu_width = 12,
    parameter int WIN       = 16,
    localparam int CW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 calc_1,
    input  logic [CH-1:0]        calc_in,
    input  logic [agg_width-1:0] thresh,
    output logic [alu_width-1:0] agg_out2alu,
    output logic [CW-1:0]        agg_ch,
    output logic                 agg_out_valid,
    input  logic                 agg_out_ready,
    output logic                 agg_out_acted,
    output logic                 agg_overrun
);

    localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int XW = (agg_width > alu_width) ? agg_width : alu_width;
    localparam logic [WW-1:0] WLAST = WW'(WIN - 1);
    localparam logic [CW-1:0] CLAST = CW'(CH - 1);

    if (WIN < CH) begin : g_win_check
        $error("calc_agg_mc: WIN must be >= CH");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WW-1:0]          r_wcnt;
    logic [agg_width-1:0]   r_acc     [CH];
    logic [agg_width-1:0]   r_buf_val [CH];
    logic [CH-1:0]          r_buf_act;
    logic [CW-1:0]          r_ch;
    logic                   r_valid;
    logic [alu_width-1:0]   r_data;
    logic                   r_act;
    logic                   r_overrun;

    logic                   w_snap;
    logic [agg_width-1:0]   w_snap_val [CH];
    logic [CH-1:0]          w_snap_act;
    logic                   w_load;
    logic                   w_drop;
    logic [CW-1:0]          w_ch_nxt;
    logic [agg_width-1:0]   w_sel_val;
    logic                   w_sel_act;

    function automatic logic [agg_width-1:0] sat_inc(input logic [agg_width-1:0] a, input logic b);
        if (b && (a != {agg_width{1'b1}})) begin
            sat_inc = a + agg_width'(1);
        end else begin
            sat_inc = a;
        end
    endfunction

    // Narrowing to the ALU bus clamps instead of truncating.
    function automatic logic [alu_width-1:0] to_alu(input logic [agg_width-1:0] v);
        logic [XW-1:0] ext;
        logic [XW-1:0] lim;
        ext = XW'(v);
        lim = XW'({alu_width{1'b1}});
        if (ext > lim) begin
            to_alu = lim[alu_width-1:0];
        end else begin
            to_alu = ext[alu_width-1:0];
        end
    endfunction

    assign w_snap = calc_1 && (r_wcnt == WLAST);

    // Per-lane next count (including this cycle's bit) and threshold flag.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_snap_val[c] = sat_inc(r_acc[c], calc_in[c]);
            w_snap_act[c] = (w_snap_val[c] >= thresh);
        end
    end

    // Drain FSM next state; a snapshot is accepted only when the buffer is free by this edge.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_snap) begin
                    w_load      = 1'b1;
                    w_ch_nxt    = {CW{1'b0}};
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (agg_out_ready && (r_ch != CLAST)) begin
                    w_ch_nxt = r_ch + CW'(1);
                    w_drop   = w_snap;
                end else if (agg_out_ready) begin
                    if (w_snap) begin
                        w_load   = 1'b1;
                        w_ch_nxt = {CW{1'b0}};
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_ch_nxt    = {CW{1'b0}};
                    end
                end else begin
                    w_drop = w_snap;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ch_nxt    = {CW{1'b0}};
            end
        endcase
    end

    // Lane presented next cycle: fresh snapshot data on load, otherwise the buffered entry.
    always_comb begin
        if (w_load) begin
            w_sel_val = w_snap_val[0];
            w_sel_act = w_snap_act[0];
        end else begin
            w_sel_val = r_buf_val[w_ch_nxt];
            w_sel_act = r_buf_act[w_ch_nxt];
        end
    end

    // Window counter and per-lane accumulators; both restart at the snapshot edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt <= {WW{1'b0}};
            for (int c = 0; c < CH; c++) begin
                r_acc[c] <= {agg_width{1'b0}};
            end
        end else if (calc_1) begin
            if (r_wcnt == WLAST) begin
                r_wcnt <= {WW{1'b0}};
                for (int c = 0; c < CH; c++) begin
                    r_acc[c] <= {agg_width{1'b0}};
                end
            end else begin
                r_wcnt <= r_wcnt + WW'(1);
                for (int c = 0; c < CH; c++) begin
                    r_acc[c] <= w_snap_val[c];
                end
            end
        end
    end

    // Result buffer capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_act <= {CH{1'b0}};
            for (int c = 0; c < CH; c++) begin
                r_buf_val[c] <= {agg_width{1'b0}};
            end
        end else if (w_load) begin
            r_buf_act <= w_snap_act;
            for (int c = 0; c < CH; c++) begin
                r_buf_val[c] <= w_snap_val[c];
            end
        end
    end

    // FSM state and registered output port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ch      <= {CW{1'b0}};
            r_valid   <= 1'b0;
            r_data    <= {alu_width{1'b0}};
            r_act     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ch      <= w_ch_nxt;
            r_valid   <= (w_state_nxt == ST_DRAIN);
            r_data    <= (w_state_nxt == ST_DRAIN) ? to_alu(w_sel_val) : {alu_width{1'b0}};
            r_act     <= (w_state_nxt == ST_DRAIN) ? w_sel_act : 1'b0;
            r_overrun <= r_overrun | w_drop;
        end
    end

    assign agg_out2alu   = r_data;
    assign agg_ch        = r_ch;
    assign agg_out_valid = r_valid;
    assign agg_out_acted = r_act;
    assign agg_overrun   = r_overrun;

endmodule
